// File: rtl/ysyx_22041211_lsu_pkg.sv
// rtl/ysyx_22041211_lsu_pkg.sv - shared LSU encodings, byte masks and FSM states
package ysyx_22041211_lsu_pkg;

  localparam logic [2:0] LOAD_NONE = 3'b000;
  localparam logic [2:0] LOAD_LB   = 3'b001;
  localparam logic [2:0] LOAD_LH   = 3'b010;
  localparam logic [2:0] LOAD_LW   = 3'b011;
  localparam logic [2:0] LOAD_LBU  = 3'b100;
  localparam logic [2:0] LOAD_LHU  = 3'b101;
  localparam logic [2:0] LOAD_LWU  = 3'b110;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SB   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SW   = 2'b11;

  localparam logic [7:0] MEM_MASK_8  = 8'h01;
  localparam logic [7:0] MEM_MASK_16 = 8'h03;
  localparam logic [7:0] MEM_MASK_32 = 8'h0f;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [2:0] load_type, input logic [1:0] store_type);
    return (load_type != LOAD_NONE) || (store_type != STORE_NONE);
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// rtl/ysyx_22041211_lsu_align.sv - combinational store lane shift/mask and load shift/extend
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [$clog2(DATA_LEN/8)-1:0] off,
  input  logic [1:0]                    store_type,
  input  logic [DATA_LEN-1:0]           store_data,
  output logic [DATA_LEN-1:0]           store_wdata,
  output logic [DATA_LEN/8-1:0]         store_wmask,
  input  logic [2:0]                    load_type,
  input  logic [DATA_LEN-1:0]           load_word,
  output logic [DATA_LEN-1:0]           load_data
);

  localparam int STRB_LEN = DATA_LEN / 8;

  logic [STRB_LEN-1:0] base_mask;
  logic [DATA_LEN-1:0] shifted;

  // Lanes shifted past the top of the word simply fall off.
  always_comb begin
    base_mask = '0;
    case (store_type)
      STORE_SB: base_mask = STRB_LEN'(MEM_MASK_8);
      STORE_SH: base_mask = STRB_LEN'(MEM_MASK_16);
      STORE_SW: base_mask = STRB_LEN'(MEM_MASK_32);
      default:  base_mask = '0;
    endcase
    store_wmask = base_mask << off;
    store_wdata = store_data << {off, 3'b000};
  end

  always_comb begin
    shifted = load_word >> {off, 3'b000};
    case (load_type)
      LOAD_LB:  load_data = DATA_LEN'(signed'(shifted[7:0]));
      LOAD_LH:  load_data = DATA_LEN'(signed'(shifted[15:0]));
      LOAD_LW:  load_data = DATA_LEN'(signed'(shifted[31:0]));
      LOAD_LBU: load_data = DATA_LEN'(shifted[7:0]);
      LOAD_LHU: load_data = DATA_LEN'(shifted[15:0]);
      LOAD_LWU: load_data = DATA_LEN'(shifted[31:0]);
      default:  load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu_hs.sv
// rtl/ysyx_22041211_lsu_hs.sv - handshaked load/store unit between EXU and WBU
// Optional alignment fault detection: YSYX_22041211_LSU_MISALIGN_EN.
module ysyx_22041211_lsu_hs
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wd_i,
  input  logic [4:0]            wreg_i,
  input  logic [DATA_LEN-1:0]   alu_result_i,
  input  logic [DATA_LEN-1:0]   mem_wdata_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [DATA_LEN-1:0]   csr_wdata_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wd_o,
  output logic [4:0]            wreg_o,
  output logic [DATA_LEN-1:0]   csr_wdata_o,
  output logic [DATA_LEN-1:0]   wdata_o,
  output logic                  memory_inst_o,
  output logic                  misalign_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_LEN-1:0]   mem_req_addr,
  output logic [DATA_LEN-1:0]   mem_req_wdata,
  output logic [DATA_LEN/8-1:0] mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_resp_rdata
);

  localparam int STRB_LEN = DATA_LEN / 8;
  localparam int OFF_LEN  = $clog2(STRB_LEN);

  lsu_state_t          state;
  logic [OFF_LEN-1:0]  off_q;
  logic [2:0]          load_q;

  logic                accept;
  logic                is_mem;
  logic                is_mis;
  logic [1:0]          store_eff;
  logic [OFF_LEN-1:0]  off_sel;
  logic [2:0]          load_sel;
  logic [DATA_LEN-1:0] st_wdata;
  logic [STRB_LEN-1:0] st_wmask;
  logic [DATA_LEN-1:0] ld_data;

  assign accept    = in_valid && in_ready;
  assign is_mem    = is_mem_op(load_type_i, store_type_i);
  // A load wins over a simultaneous store.
  assign store_eff = (load_type_i != LOAD_NONE) ? STORE_NONE : store_type_i;
  // The shared aligner sees live inputs while idle and the latched op afterwards.
  assign off_sel   = (state == LSU_IDLE) ? alu_result_i[OFF_LEN-1:0] : off_q;
  assign load_sel  = (state == LSU_IDLE) ? load_type_i : load_q;

`ifdef YSYX_22041211_LSU_MISALIGN_EN
  logic half_acc;
  logic word_acc;
  assign half_acc = (load_type_i == LOAD_LH) || (load_type_i == LOAD_LHU) || (store_eff == STORE_SH);
  assign word_acc = (load_type_i == LOAD_LW) || (load_type_i == LOAD_LWU) || (store_eff == STORE_SW);
  assign is_mis   = (half_acc && alu_result_i[0]) || (word_acc && (alu_result_i[1:0] != 2'b00));
`else
  assign is_mis = 1'b0;
`endif

  ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
    .off         (off_sel),
    .store_type  (store_eff),
    .store_data  (mem_wdata_i),
    .store_wdata (st_wdata),
    .store_wmask (st_wmask),
    .load_type   (load_sel),
    .load_word   (mem_resp_rdata),
    .load_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LSU_IDLE;
      in_ready      <= 1'b0;
      off_q         <= '0;
      load_q        <= LOAD_NONE;
      out_valid     <= 1'b0;
      wd_o          <= 1'b0;
      wreg_o        <= '0;
      csr_wdata_o   <= '0;
      wdata_o       <= '0;
      memory_inst_o <= 1'b0;
      misalign_o    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready      <= 1'b0;
            wd_o          <= wd_i && !is_mis;
            wreg_o        <= wreg_i;
            csr_wdata_o   <= csr_wdata_i;
            wdata_o       <= alu_result_i;
            memory_inst_o <= is_mem;
            misalign_o    <= is_mis;
            off_q         <= alu_result_i[OFF_LEN-1:0];
            load_q        <= load_type_i;
            if (is_mem && !is_mis) begin
              state         <= LSU_REQ;
              mem_req_valid <= 1'b1;
              mem_req_wen   <= (store_eff != STORE_NONE);
              mem_req_addr  <= {alu_result_i[ADDR_LEN-1:OFF_LEN], {OFF_LEN{1'b0}}};
              mem_req_wdata <= (store_eff != STORE_NONE) ? st_wdata : '0;
              mem_req_wmask <= st_wmask;
            end else begin
              state     <= LSU_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (mem_resp_valid) begin
            if (load_q != LOAD_NONE) wdata_o <= ld_data;
            out_valid <= 1'b1;
            state     <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu_hs.sv
// tb/tb_ysyx_22041211_lsu_hs.sv - directed self-checking bench for ysyx_22041211_lsu_hs
module tb_ysyx_22041211_lsu_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] csr_wdata_i;
  logic        out_valid;
  logic        out_ready;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] wdata_o;
  logic        memory_inst_o;
  logic        misalign_o;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  ysyx_22041211_lsu_hs #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .wd_i           (wd_i),
    .wreg_i         (wreg_i),
    .alu_result_i   (alu_result_i),
    .mem_wdata_i    (mem_wdata_i),
    .load_type_i    (load_type_i),
    .store_type_i   (store_type_i),
    .csr_wdata_i    (csr_wdata_i),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .csr_wdata_o    (csr_wdata_o),
    .wdata_o        (wdata_o),
    .memory_inst_o  (memory_inst_o),
    .misalign_o     (misalign_o),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) xfers++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [31:0] sdata, input logic [2:0] lt, input logic [1:0] st);
    in_valid     = 1'b1;
    alu_result_i = alu;
    mem_wdata_i  = sdata;
    load_type_i  = lt;
    store_type_i = st;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
    checks++;
    if ({out_valid, mem_req_valid, wd_o, memory_inst_o, misalign_o, mem_req_wen} !== 6'b0 || wdata_o !== 32'h0 || mem_req_wmask !== 4'h0 || mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got ov=%b rv=%b wdata=%h mask=%h addr=%h required all zero", out_valid, mem_req_valid, wdata_o, mem_req_wmask, mem_req_addr);
    end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_alu_pass();
    wd_i = 1'b1; wreg_i = 5'd5; csr_wdata_i = 32'h55;
    send(32'h1234, 32'h0, 3'b000, 2'b00);
    checks++; if (out_valid !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL alu_latency got ov=%b rv=%b required ov=1 rv=0", out_valid, mem_req_valid); end
    checks++; if (wdata_o !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h required 00001234", wdata_o); end
    checks++;
    if (wd_o !== 1'b1 || wreg_o !== 5'd5 || csr_wdata_o !== 32'h55 || memory_inst_o !== 1'b0) begin
      errors++; $display("FAIL alu_bundle got wd=%b wreg=%0d csr=%h mi=%b required 1 5 00000055 0", wd_o, wreg_o, csr_wdata_o, memory_inst_o);
    end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL alu_return got ov=%b ir=%b required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    send(32'h1, 32'h0, 3'b000, 2'b00);
    in_valid = 1'b1; alu_result_i = 32'h2;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || wdata_o !== 32'h1) begin errors++; $display("FAIL b2b_first got ov=%b ir=%b wdata=%h required 1 0 00000001", out_valid, in_ready, wdata_o); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got ov=%b ir=%b required 0 1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h2) begin errors++; $display("FAIL b2b_second got ov=%b wdata=%h required 1 00000002", out_valid, wdata_o); end
    step();
  endtask

  task automatic test_load_extend();
    logic [2:0]  lt  [2] = '{3'b001, 3'b100};
    logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int i = 0; i < 2; i++) begin
      send(32'h8000_0003, 32'h0, lt[i], 2'b00);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 || mem_req_wmask !== 4'h0) begin
        errors++; $display("FAIL load_req[%0d] got rv=%b addr=%h wen=%b mask=%h required 1 80000000 0 0", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
      end
      step();
      checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL load_resp_wait[%0d] got rv=%b ov=%b required 0 0", i, mem_req_valid, out_valid); end
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_FF00;
      step();
      mem_resp_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || wdata_o !== exp[i] || memory_inst_o !== 1'b1) begin
        errors++; $display("FAIL load_data[%0d] got ov=%b wdata=%h mi=%b required 1 %h 1", i, out_valid, wdata_o, memory_inst_o, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_store_sh();
    send(32'h8000_0002, 32'h0000_ABCD, 3'b000, 2'b10);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wmask !== 4'b1100 || mem_req_wdata !== 32'hABCD_0000 || mem_req_wen !== 1'b1) begin
      errors++; $display("FAIL store_sh_req got rv=%b addr=%h mask=%b wdata=%h wen=%b required 1 80000000 1100 abcd0000 1", mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wdata, mem_req_wen);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h8000_0002) begin errors++; $display("FAIL store_sh_wb got ov=%b wdata=%h required 1 80000002", out_valid, wdata_o); end
    step();
  endtask

  task automatic test_backpressure();
    int x0;
    x0 = xfers;
    mem_req_ready = 1'b0; out_ready = 1'b0;
    send(32'h8000_0004, 32'h1122_3344, 3'b000, 2'b11);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || mem_req_wmask !== 4'hF || mem_req_wdata !== 32'h1122_3344) begin
        errors++; $display("FAIL bp_req_hold[%0d] got rv=%b addr=%h mask=%h wdata=%h required 1 80000004 f 11223344", i, mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wdata);
      end
      if (i == 2) mem_req_ready = 1'b1;
      step();
    end
    checks++; if (mem_req_valid !== 1'b0 || xfers - x0 !== 1) begin errors++; $display("FAIL bp_one_xfer got rv=%b xfers=%0d required 0 1", mem_req_valid, xfers - x0); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || wdata_o !== 32'h8000_0004 || wreg_o !== 5'd5 || memory_inst_o !== 1'b1) begin
        errors++; $display("FAIL bp_out_hold[%0d] got ov=%b wdata=%h wreg=%0d mi=%b required 1 80000004 5 1", i, out_valid, wdata_o, wreg_o, memory_inst_o);
      end
      if (i == 2) out_ready = 1'b1;
      step();
    end
    checks++; if (out_valid !== 1'b0 || xfers - x0 !== 1) begin errors++; $display("FAIL bp_done got ov=%b xfers=%0d required 0 1", out_valid, xfers - x0); end
  endtask

  task automatic test_misalign();
    send(32'h8000_0001, 32'h0, 3'b011, 2'b00);
`ifdef YSYX_22041211_LSU_MISALIGN_EN
    checks++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b1 || misalign_o !== 1'b1 || wd_o !== 1'b0) begin
      errors++; $display("FAIL misalign_fault got rv=%b ov=%b mis=%b wd=%b required 0 1 1 0", mem_req_valid, out_valid, misalign_o, wd_o);
    end
    step();
    checks++; if (xfers !== 1 + 2 + 1) begin errors++; $display("FAIL misalign_no_bus got xfers=%0d required 4", xfers); end
`else
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_wmask !== 4'h0 || mem_req_addr !== 32'h8000_0000 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL misalign_bus got rv=%b mask=%h addr=%h mis=%b required 1 0 80000000 0", mem_req_valid, mem_req_wmask, mem_req_addr, misalign_o);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h00DE_ADBE || wd_o !== 1'b1) begin errors++; $display("FAIL misalign_lw_data got ov=%b wdata=%h wd=%b required 1 00deadbe 1", out_valid, wdata_o, wd_o); end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    send(32'h8000_0000, 32'h0, 3'b001, 2'b00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got ov=%b rv=%b required 0 0", out_valid, mem_req_valid); end
    step();
    mem_resp_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got ov=%b ir=%b required 0 1", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || wdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_stale_resp got ov=%b wdata=%h required 0 00000000", out_valid, wdata_o); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; wd_i = 1'b0; wreg_i = '0; alu_result_i = '0; mem_wdata_i = '0;
    load_type_i = '0; store_type_i = '0; csr_wdata_i = '0; out_ready = 1'b1; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    test_reset();
    test_alu_pass();
    test_back_to_back();
    test_load_extend();
    test_store_sh();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
